// File: rtl/sram_access_ctrl.sv
// MEM-stage load/store sequencer for a 16-bit async SRAM: each 32-bit word moves as LO then HI half-word phases.
// Optional SRAM_ALIGN_CHECK_EN adds a 'misaligned' pulse on acceptance of a non-word-aligned request.
module sram_access_ctrl #(
  parameter int          WORD_WIDTH  = 32,
  parameter int          SRAM_AW     = 18,
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  MEM_R_EN,
  input  logic                  MEM_W_EN,
  input  logic [WORD_WIDTH-1:0] ALU_Res,
  input  logic [WORD_WIDTH-1:0] Val_Rm,
  output logic                  ready,
  output logic [WORD_WIDTH-1:0] read_data,
  output logic [SRAM_AW-1:0]    SRAM_ADDR,
  output logic [15:0]           SRAM_DQ_out,
  input  logic [15:0]           SRAM_DQ_in,
  output logic                  SRAM_DQ_oe,
  output logic                  SRAM_WE_N,
  output logic                  SRAM_OE_N
`ifdef SRAM_ALIGN_CHECK_EN
  ,
  output logic                  misaligned
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_t;

  localparam logic [2:0] LP_LAST = 3'(WAIT_CYCLES);

  state_t                r_state;
  state_t                w_next;
  logic [2:0]            r_cnt;
  logic                  r_rd;
  logic [SRAM_AW-2:0]    r_widx;
  logic [WORD_WIDTH-1:0] r_wdat;

  logic [WORD_WIDTH-1:0] w_off;
  logic [SRAM_AW-2:0]    w_widx;
  logic                  w_req;
  logic                  w_last;
  logic                  w_phase;
  logic                  w_unused;

  assign w_off    = ALU_Res - WORD_WIDTH'(BASE_ADDR);
  assign w_widx   = w_off[SRAM_AW:2];
  assign w_req    = MEM_R_EN | MEM_W_EN;
  assign w_last   = (r_cnt == LP_LAST);
  assign w_phase  = (r_state == S_LO) || (r_state == S_HI);
  assign w_unused = ^{w_off[WORD_WIDTH-1:SRAM_AW+1], w_off[1:0]};

`ifdef SRAM_ALIGN_CHECK_EN
  assign misaligned = rst && (r_state == S_IDLE) && w_req && (w_off[1:0] != 2'b00);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_req)  w_next = S_LO;
      S_LO:    if (w_last) w_next = S_HI;
      S_HI:    if (w_last) w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    ready       = ((r_state == S_IDLE) && !w_req) || (r_state == S_DONE);
    SRAM_ADDR   = '0;
    SRAM_DQ_out = 16'h0000;
    SRAM_DQ_oe  = 1'b0;
    SRAM_WE_N   = 1'b1;
    SRAM_OE_N   = 1'b1;
    if (w_phase) begin
      SRAM_ADDR = {r_widx, (r_state == S_HI)};
      if (r_rd) begin
        SRAM_OE_N = 1'b0;
      end else begin
        SRAM_DQ_oe  = 1'b1;
        SRAM_DQ_out = (r_state == S_HI) ? r_wdat[31:16] : r_wdat[15:0];
        // Last cycle of a multi-cycle phase releases WE_N so data is held past the strobe.
        SRAM_WE_N   = (LP_LAST != 3'd0) && w_last;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt     <= 3'd0;
      r_rd      <= 1'b0;
      r_widx    <= '0;
      r_wdat    <= '0;
      read_data <= '0;
    end else if (r_state == S_IDLE) begin
      r_cnt <= 3'd0;
      if (w_req) begin
        r_rd   <= MEM_R_EN;
        r_widx <= w_widx;
        r_wdat <= Val_Rm;
      end
    end else if (w_phase) begin
      r_cnt <= w_last ? 3'd0 : r_cnt + 3'd1;
      if (w_last && r_rd) begin
        if (r_state == S_LO) read_data[15:0]  <= SRAM_DQ_in;
        else                 read_data[31:16] <= SRAM_DQ_in;
      end
    end
  end

endmodule
